// File: rtl/core_pkg.sv
// Shared core definitions: data width and writeback source select codes
// used by decode, the pipeline registers and the writeback stage.
package core_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] WB_SEL_ALU = 2'b00;
  localparam logic [1:0] WB_SEL_MEM = 2'b01;
  localparam logic [1:0] WB_SEL_PC4 = 2'b10;
  localparam logic [1:0] WB_SEL_IMM = 2'b11;

  typedef logic [4:0] reg_idx_t;

endpackage

// File: rtl/wb_regfile_if.sv
// Writeback control/result buses, the decode read ports and the
// retire counter of the writeback stage, bundled as one interface.
interface wb_regfile_if #(parameter int XLEN = core_pkg::XLEN);
  import core_pkg::*;

  reg_idx_t          wb_wr_index_in;
  logic              wb_wr_en_in;
  logic [1:0]        wb_data_sel_in;
  logic [XLEN-1:0]   alu_result_in;
  logic [XLEN-1:0]   mem_rd_data_in;
  logic [XLEN-1:0]   pc_plus4_in;
  logic [XLEN-1:0]   imm_in;
  reg_idx_t          rd_index_a;
  reg_idx_t          rd_index_b;
  logic [XLEN-1:0]   rd_data_a;
  logic [XLEN-1:0]   rd_data_b;
  logic [XLEN-1:0]   wb_data_out;
  logic              wb_valid_out;
  logic [31:0]       retire_count;

  modport master (
    output wb_wr_index_in, wb_wr_en_in, wb_data_sel_in, alu_result_in,
           mem_rd_data_in, pc_plus4_in, imm_in, rd_index_a, rd_index_b,
    input  rd_data_a, rd_data_b, wb_data_out, wb_valid_out, retire_count
  );

  modport slave (
    input  wb_wr_index_in, wb_wr_en_in, wb_data_sel_in, alu_result_in,
           mem_rd_data_in, pc_plus4_in, imm_in, rd_index_a, rd_index_b,
    output rd_data_a, rd_data_b, wb_data_out, wb_valid_out, retire_count
  );

endinterface

// File: rtl/rf_array.sv
// Raw storage for architectural registers x1..x31: one write port, two
// read ports. Index 0 has no flops and reads back as zero.
module rf_array #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [4:0]      raddr_a,
  output logic [XLEN-1:0] rdata_a,
  input  logic [4:0]      raddr_b,
  output logic [XLEN-1:0] rdata_b
);

  logic [XLEN-1:0] regs_r [1:31];

  // Register storage with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < 32; i++) begin
        regs_r[i] <= '0;
      end
    end else if (we && (waddr != 5'd0)) begin
      regs_r[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == 5'd0) ? '0 : regs_r[raddr_a];
  assign rdata_b = (raddr_b == 5'd0) ? '0 : regs_r[raddr_b];

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: selects the result to commit, writes the register file,
// serves two combinational read ports with optional bypass, counts commits.
module wb_regfile #(
  parameter int XLEN   = core_pkg::XLEN,
  parameter bit BYPASS = 1'b1
) (
  input logic        clk,
  input logic        rst,
  wb_regfile_if.slave bus
);
  import core_pkg::*;

  logic [XLEN-1:0] wb_data_s;
  logic            wb_valid_s;
  logic [XLEN-1:0] raw_a_s;
  logic [XLEN-1:0] raw_b_s;
  logic [31:0]     retire_count_r;

  function automatic logic [XLEN-1:0] read_port(
    input logic [4:0]      idx,
    input logic [XLEN-1:0] raw,
    input logic            valid,
    input logic [4:0]      widx,
    input logic [XLEN-1:0] wdata
  );
    if (idx == 5'd0) begin
      return '0;
    end else if (BYPASS && valid && (idx == widx)) begin
      return wdata;
    end else begin
      return raw;
    end
  endfunction

  // Writeback source mux; an undefined select falls back to the ALU result
  always_comb begin
    wb_data_s = bus.alu_result_in;
    case (bus.wb_data_sel_in)
      WB_SEL_ALU: wb_data_s = bus.alu_result_in;
      WB_SEL_MEM: wb_data_s = bus.mem_rd_data_in;
      WB_SEL_PC4: wb_data_s = bus.pc_plus4_in;
      WB_SEL_IMM: wb_data_s = bus.imm_in;
      default:    wb_data_s = bus.alu_result_in;
    endcase
  end

  assign wb_valid_s = bus.wb_wr_en_in && (bus.wb_wr_index_in != 5'd0);

  rf_array #(.XLEN(XLEN)) u_rf_array (
    .clk     (clk),
    .rst     (rst),
    .we      (wb_valid_s),
    .waddr   (bus.wb_wr_index_in),
    .wdata   (wb_data_s),
    .raddr_a (bus.rd_index_a),
    .rdata_a (raw_a_s),
    .raddr_b (bus.rd_index_b),
    .rdata_b (raw_b_s)
  );

  // Committed-write counter, wraps silently
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retire_count_r <= 32'd0;
    end else if (wb_valid_s) begin
      retire_count_r <= retire_count_r + 32'd1;
    end
  end

  assign bus.rd_data_a    = read_port(bus.rd_index_a, raw_a_s, wb_valid_s,
                                      bus.wb_wr_index_in, wb_data_s);
  assign bus.rd_data_b    = read_port(bus.rd_index_b, raw_b_s, wb_valid_s,
                                      bus.wb_wr_index_in, wb_data_s);
  assign bus.wb_data_out  = wb_data_s;
  assign bus.wb_valid_out = wb_valid_s;
  assign bus.retire_count = retire_count_r;

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: a bypassing and a non-bypassing instance share one
// stimulus stream and are compared every cycle against an array model.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wen;
  logic [4:0]  widx;
  logic [1:0]  sel;
  logic [31:0] alu, mem, pc, imm;
  logic [4:0]  ra, rb;

  int unsigned checks = 0;
  int unsigned errors = 0;
  bit          cmp_en = 1'b0;

  logic [31:0] m_regs [32];
  logic [31:0] m_count;

  always #5 clk = ~clk;

  wb_regfile_if bus_byp ();
  wb_regfile_if bus_nob ();

  assign bus_byp.wb_wr_en_in    = wen;
  assign bus_byp.wb_wr_index_in = widx;
  assign bus_byp.wb_data_sel_in = sel;
  assign bus_byp.alu_result_in  = alu;
  assign bus_byp.mem_rd_data_in = mem;
  assign bus_byp.pc_plus4_in    = pc;
  assign bus_byp.imm_in         = imm;
  assign bus_byp.rd_index_a     = ra;
  assign bus_byp.rd_index_b     = rb;

  assign bus_nob.wb_wr_en_in    = wen;
  assign bus_nob.wb_wr_index_in = widx;
  assign bus_nob.wb_data_sel_in = sel;
  assign bus_nob.alu_result_in  = alu;
  assign bus_nob.mem_rd_data_in = mem;
  assign bus_nob.pc_plus4_in    = pc;
  assign bus_nob.imm_in         = imm;
  assign bus_nob.rd_index_a     = ra;
  assign bus_nob.rd_index_b     = rb;

  wb_regfile #(.XLEN(32), .BYPASS(1'b1)) dut_byp (.clk(clk), .rst(rst), .bus(bus_byp));
  wb_regfile #(.XLEN(32), .BYPASS(1'b0)) dut_nob (.clk(clk), .rst(rst), .bus(bus_nob));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_sel_val();
    case (sel)
      2'b00:   return alu;
      2'b01:   return mem;
      2'b10:   return pc;
      2'b11:   return imm;
      default: return alu;
    endcase
  endfunction

  function automatic logic m_commit();
    return (wen === 1'b1) && (widx != 5'd0);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] idx, input bit byp);
    if (idx == 5'd0) return 32'd0;
    if (byp && m_commit() && (widx == idx)) return m_sel_val();
    return m_regs[idx];
  endfunction

  // Reference state: architectural registers and commit count
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      foreach (m_regs[i]) m_regs[i] = 32'd0;
      m_count = 32'd0;
    end else if (m_commit()) begin
      m_regs[widx] = m_sel_val();
      m_count      = m_count + 32'd1;
    end
  end

  // Per-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("valid_byp", {31'd0, bus_byp.wb_valid_out}, {31'd0, m_commit()});
      chk("valid_nob", {31'd0, bus_nob.wb_valid_out}, {31'd0, m_commit()});
      if (!$isunknown(sel)) begin
        chk("wbdata_byp", bus_byp.wb_data_out, m_sel_val());
        chk("wbdata_nob", bus_nob.wb_data_out, m_sel_val());
      end
      chk("rda_byp", bus_byp.rd_data_a, m_read(ra, 1'b1));
      chk("rdb_byp", bus_byp.rd_data_b, m_read(rb, 1'b1));
      chk("rda_nob", bus_nob.rd_data_a, m_read(ra, 1'b0));
      chk("rdb_nob", bus_nob.rd_data_b, m_read(rb, 1'b0));
      chk("retire_byp", bus_byp.retire_count, m_count);
      chk("retire_nob", bus_nob.retire_count, m_count);
    end
  end

  task automatic apply(input logic w, input logic [4:0] wi, input logic [1:0] s,
                       input logic [31:0] d, input logic [4:0] a, input logic [4:0] b);
    @(posedge clk);
    #1;
    wen = w; widx = wi; sel = s; ra = a; rb = b;
    alu = (s == 2'b00) ? d : 32'h1111_0000;
    mem = (s == 2'b01) ? d : 32'h2222_0000;
    pc  = (s == 2'b10) ? d : 32'h3333_0000;
    imm = (s == 2'b11) ? d : 32'h4444_0000;
  endtask

  task automatic at_sample();
    @(negedge clk);
    #1;
  endtask

  initial begin
    foreach (m_regs[i]) m_regs[i] = 32'd0;
    m_count = 32'd0;
    wen = 1'b0; widx = 5'd0; sel = 2'b00; ra = 5'd0; rb = 5'd0;
    alu = 32'd0; mem = 32'd0; pc = 32'd0; imm = 32'd0;
    cmp_en = 1'b1;

    // Reset: every index reads zero on both ports
    for (int i = 0; i < 32; i++) begin
      apply(1'b0, 5'd0, 2'b00, 32'd0, i[4:0], 5'(31 - i));
      at_sample();
      chk("rst_rda", bus_byp.rd_data_a, 32'd0);
      chk("rst_rdb", bus_nob.rd_data_b, 32'd0);
    end
    chk("rst_retire", bus_byp.retire_count, 32'd0);

    // ALU to x5, then MEM to x6
    apply(1'b1, 5'd5, 2'b00, 32'h0000_1234, 5'd5, 5'd6);
    rst = 1'b0;
    at_sample();
    chk("byp_x5", bus_byp.rd_data_a, 32'h0000_1234);
    chk("nob_x5_old", bus_nob.rd_data_a, 32'd0);
    apply(1'b1, 5'd6, 2'b01, 32'hFFFF_FF80, 5'd5, 5'd6);
    at_sample();
    chk("nob_x5", bus_nob.rd_data_a, 32'h0000_1234);
    apply(1'b0, 5'd0, 2'b00, 32'd0, 5'd5, 5'd6);
    at_sample();
    chk("x5", bus_nob.rd_data_a, 32'h0000_1234);
    chk("x6", bus_nob.rd_data_b, 32'hFFFF_FF80);
    chk("retire2", bus_byp.retire_count, 32'd2);

    // Write to x0 is discarded
    apply(1'b1, 5'd0, 2'b11, 32'hDEAD_B000, 5'd0, 5'd0);
    at_sample();
    chk("x0_valid", {31'd0, bus_byp.wb_valid_out}, 32'd0);
    chk("x0_wbdata", bus_byp.wb_data_out, 32'hDEAD_B000);
    chk("x0_rd", bus_byp.rd_data_a, 32'd0);

    // Same-cycle bypass of PC+4 to x7 on both ports
    apply(1'b1, 5'd7, 2'b10, 32'h0000_0104, 5'd7, 5'd7);
    at_sample();
    chk("retire_x0", bus_byp.retire_count, 32'd2);
    chk("byp_x7a", bus_byp.rd_data_a, 32'h0000_0104);
    chk("byp_x7b", bus_byp.rd_data_b, 32'h0000_0104);
    chk("nob_x7_old", bus_nob.rd_data_a, 32'd0);

    // Bubble with undefined select aimed at x9
    apply(1'b0, 5'd9, 2'b00, 32'hBAD0_0009, 5'd7, 5'd9);
    sel = 2'bxx;
    at_sample();
    chk("nob_x7", bus_nob.rd_data_b, 32'd0);
    chk("nob_x7a", bus_nob.rd_data_a, 32'h0000_0104);
    chk("x9_keep", bus_byp.rd_data_b, 32'd0);
    chk("rd_known", {31'd0, $isunknown({bus_byp.rd_data_a, bus_byp.rd_data_b})}, 32'd0);
    apply(1'b0, 5'd0, 2'b00, 32'd0, 5'd9, 5'd7);
    at_sample();
    chk("retire3", bus_byp.retire_count, 32'd3);

    // Asynchronous reset between edges after writing x3
    apply(1'b1, 5'd3, 2'b00, 32'hA5A5_A5A5, 5'd3, 5'd3);
    apply(1'b0, 5'd0, 2'b00, 32'd0, 5'd3, 5'd7);
    at_sample();
    chk("x3", bus_byp.rd_data_a, 32'hA5A5_A5A5);
    chk("retire4", bus_nob.retire_count, 32'd4);
    #1 rst = 1'b1;
    #1;
    chk("arst_x3", bus_byp.rd_data_a, 32'd0);
    chk("arst_x7", bus_nob.rd_data_b, 32'd0);
    chk("arst_retire", bus_byp.retire_count, 32'd0);
    apply(1'b1, 5'd4, 2'b00, 32'h0000_0044, 5'd4, 5'd3);
    at_sample();
    apply(1'b0, 5'd0, 2'b00, 32'd0, 5'd4, 5'd3);
    rst = 1'b0;
    at_sample();
    chk("no_commit_in_rst", bus_nob.rd_data_a, 32'd0);

    // Counter wrap from a preloaded value
    @(posedge clk);
    #1;
    force dut_byp.retire_count_r = 32'hFFFF_FFFE;
    force dut_nob.retire_count_r = 32'hFFFF_FFFE;
    m_count = 32'hFFFF_FFFE;
    #1;
    release dut_byp.retire_count_r;
    release dut_nob.retire_count_r;
    wen = 1'b1; widx = 5'd1; sel = 2'b00; alu = 32'h0000_0001;
    at_sample();
    apply(1'b1, 5'd2, 2'b01, 32'h0000_0002, 5'd1, 5'd2);
    at_sample();
    chk("retire_max", bus_byp.retire_count, 32'hFFFF_FFFF);
    apply(1'b0, 5'd0, 2'b00, 32'd0, 5'd1, 5'd2);
    at_sample();
    chk("retire_wrap", bus_nob.retire_count, 32'd0);
    chk("x2", bus_nob.rd_data_b, 32'h0000_0002);

    // Randomized traffic with occasional reset pulses
    for (int n = 0; n < 600; n++) begin
      @(posedge clk);
      #1;
      rst  = ($urandom_range(0, 99) == 0);
      wen  = ($urandom_range(0, 9) < 7);
      widx = 5'($urandom_range(0, 31));
      sel  = 2'($urandom_range(0, 3));
      alu  = $urandom; mem = $urandom; pc = $urandom; imm = $urandom;
      ra   = ($urandom_range(0, 3) == 0) ? widx : 5'($urandom_range(0, 31));
      rb   = ($urandom_range(0, 3) == 0) ? widx : 5'($urandom_range(0, 31));
      if (!wen && ($urandom_range(0, 3) == 0)) sel = 2'bxx;
    end
    @(posedge clk);
    #1 rst = 1'b0;
    wen = 1'b0;
    at_sample();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
